// File: rtl/div_unit.sv
// ============================================================================
// div_unit
// ----------------------------------------------------------------------------
// Multi-cycle radix-2 restoring divider for the EX stage (MIPS DIV / DIVU).
// One quotient bit is produced per cycle, so a division takes WIDTH cycles of
// iteration plus one accept cycle and one result cycle. While a division is in
// flight the unit asks the hazard unit to freeze F/D/E through stall_div.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   a          dividend (rs, post-forwarding)
//   b          divisor  (rt, post-forwarding)
//   signed_div 1 = DIV (two's complement), 0 = DIVU
//   start      divide instruction present in E, held high until ready
//   annul      abort the current operation (E-stage flush / exception)
//   result     {remainder, quotient} = {HI, LO}, held until the next result
//   ready      one-cycle pulse, result is valid in this cycle
//   stall_div  stall request to the hazard unit
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_div,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_div
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        DIV_ZERO,
        END
    } state_t;

    state_t           state;
    logic [CW-1:0]    counter;

    // dividend_q starts out holding the dividend magnitude; each iteration
    // shifts its MSB into the partial remainder and a quotient bit into its
    // LSB, so after WIDTH iterations it holds the unsigned quotient.
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH:0]   divisor_mag;
    logic [WIDTH:0]   part_rem;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] final_q;
    logic [WIDTH-1:0] final_r;

    // Operand magnitudes and one restoring step. The dividend magnitude of the
    // most negative value (2^(W-1)) still fits in WIDTH unsigned bits; the
    // divisor gets an extra bit so the trial subtraction is always unsigned.
    always_comb begin
        a_mag    = (signed_div && a[WIDTH-1]) ? -a : a;
        b_mag    = {1'b0, ((signed_div && b[WIDTH-1]) ? -b : b)};
        shifted  = {part_rem[WIDTH-1:0], dividend_q[WIDTH-1]};
        trial    = {1'b0, shifted} - {1'b0, divisor_mag};
        q_bit    = ~trial[WIDTH+1];
        rem_next = q_bit ? trial[WIDTH:0] : shifted;
        quo_next = {dividend_q[WIDTH-2:0], q_bit};
        final_q  = q_neg ? -quo_next : quo_next;
        final_r  = r_neg ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    // Control FSM and datapath registers. The result is committed on the edge
    // that enters END, so annul arriving in END cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            result      <= '0;
            ready       <= 1'b0;
            dividend_q  <= '0;
            divisor_mag <= '0;
            part_rem    <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !annul) begin
                        counter     <= '0;
                        part_rem    <= '0;
                        dividend_q  <= a_mag;
                        divisor_mag <= b_mag;
                        q_neg       <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg       <= signed_div & a[WIDTH-1];
                        state       <= (b == '0) ? DIV_ZERO : ON;
                    end
                end
                ON: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        part_rem   <= rem_next;
                        dividend_q <= quo_next;
                        counter    <= counter + CW'(1);
                        if (counter == CW'(WIDTH - 1)) begin
                            result <= {final_r, final_q};
                            ready  <= 1'b1;
                            state  <= END;
                        end
                    end
                end
                DIV_ZERO: begin
                    // Architecturally unpredictable; zero keeps it deterministic.
                    result <= '0;
                    ready  <= 1'b1;
                    state  <= END;
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The stall drops in END so the divide advances in the ready cycle. The
    // IDLE term covers the accepting cycle itself.
    always_comb begin
        stall_div = !rst && ((state == IDLE && start && !annul) ||
                             state == ON || state == DIV_ZERO);
    end

endmodule

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit
// ----------------------------------------------------------------------------
// Self-checking bench for div_unit. Expected results come from plain integer
// division in a behavioural model; expected timing comes from the documented
// latencies (WIDTH+1 cycles, or 2 for a zero divisor).
// ============================================================================
module tb_div_unit;

    localparam int W       = 32;
    localparam int TIMEOUT = 100;

    logic           clk;
    logic           rst;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_div;
    logic           start;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall_div;

    int             checks;
    int             errors;
    int             cycle_count;
    logic [2*W-1:0] last_res;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .signed_div (signed_div),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    // Free-running clock and a cycle counter used to measure pulse spacing.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Global time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: MIPS DIV/DIVU semantics from ordinary arithmetic.
    // Signed division truncates toward zero and the remainder takes the sign
    // of the dividend, which is exactly what SV / and % do on longints.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic s);
        longint          sq, sr, sx, sy;
        longint unsigned uq, ur, ux, uy;
        if (y == '0) return '0;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            sq = sx / sy;
            sr = sx % sy;
            return {sr[W-1:0], sq[W-1:0]};
        end
        ux = x;
        uy = y;
        uq = ux / uy;
        ur = ux % uy;
        return {ur[W-1:0], uq[W-1:0]};
    endfunction

    // Runs one divide with start held until ready. Operands are scrambled after
    // the accepting cycle to prove they were latched. Checks latency, result
    // and the per-cycle stall trace.
    task automatic run_div(input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic sgn, input string tag,
                           output int ready_at);
        logic [2*W-1:0] exp_res;
        int             lat;
        int             cyc;
        bit             got;
        bit             stall_bad;
        logic           stall_exp;
        exp_res   = model(ai, bi, sgn);
        lat       = (bi == '0) ? 2 : W + 1;
        a          = ai;
        b          = bi;
        signed_div = sgn;
        start      = 1'b1;
        cyc       = 0;
        got       = 0;
        stall_bad = 0;
        ready_at  = -1;
        while (!got && cyc <= TIMEOUT) begin
            @(negedge clk);
            stall_exp = (cyc < lat);
            if (stall_div !== stall_exp) stall_bad = 1;
            if (ready === 1'b1) begin
                got      = 1;
                ready_at = cycle_count;
                checks++;
                if (cyc != lat) begin
                    errors++;
                    $display("[TB] FAIL %s latency: got %0d cycles expected %0d", tag, cyc, lat);
                end
                checks++;
                if (result !== exp_res) begin
                    errors++;
                    $display("[TB] FAIL %s result: got %h expected %h", tag, result, exp_res);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                a          = $urandom;
                b          = $urandom;
                signed_div = 1'($urandom);
            end
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL %s timeout: got no ready expected ready at cycle %0d", tag, lat);
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("[TB] FAIL %s stall_trace: got wrong stall_div expected high cycles 0..%0d", tag, lat - 1);
        end
        last_res = exp_res;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || stall_div !== 1'b0 || result !== '0) begin
            errors++;
            $display("[TB] FAIL reset: got ready=%b stall=%b result=%h expected 0 0 0", ready, stall_div, result);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || stall_div !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got ready=%b stall=%b expected 0 0", ready, stall_div);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int t;
        run_div(32'd100, 32'd7, 1'b0, "udiv_100_7", t);
        checks++;
        if (result !== {32'h00000002, 32'h0000000E}) begin
            errors++;
            $display("[TB] FAIL udiv_100_7 literal: got %h expected 000000020000000e", result);
        end
    endtask

    task automatic test_signs();
        int t;
        run_div(32'hFFFFFFF9, 32'h2, 1'b1, "sdiv_m7_2", t);
        checks++;
        if (result !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            errors++;
            $display("[TB] FAIL sdiv_m7_2 literal: got %h expected fffffffffffffffd", result);
        end
        run_div(32'hFFFFFFF9, 32'h2, 1'b0, "udiv_m7_2", t);
        checks++;
        if (result !== {32'h00000001, 32'h7FFFFFFC}) begin
            errors++;
            $display("[TB] FAIL udiv_m7_2 literal: got %h expected 000000017ffffffc", result);
        end
    endtask

    task automatic test_boundaries();
        int t;
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "sdiv_overflow", t);
        checks++;
        if (result !== {32'h0, 32'h80000000}) begin
            errors++;
            $display("[TB] FAIL sdiv_overflow literal: got %h expected 0000000080000000", result);
        end
        run_div(32'hFFFFFFFF, 32'h1, 1'b0, "udiv_max_1", t);
        checks++;
        if (result !== {32'h0, 32'hFFFFFFFF}) begin
            errors++;
            $display("[TB] FAIL udiv_max_1 literal: got %h expected 00000000ffffffff", result);
        end
        run_div(32'h1234, 32'h0, 1'b0, "div_zero", t);
        checks++;
        if (result !== '0) begin
            errors++;
            $display("[TB] FAIL div_zero literal: got %h expected 0", result);
        end
    endtask

    // Abort an operation in its tenth cycle, then start a fresh one at cycle 12.
    task automatic test_annul();
        int t;
        bit early_ready;
        logic [2*W-1:0] held;
        run_div(32'd77, 32'd5, 1'b0, "pre_annul", t);
        held        = last_res;
        early_ready = 0;
        a          = 32'd1000;
        b          = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready === 1'b1) early_ready = 1;
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(negedge clk);
        if (ready === 1'b1) early_ready = 1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (early_ready || ready !== 1'b0 || stall_div !== 1'b0 || result !== held) begin
            errors++;
            $display("[TB] FAIL annul: got ready=%b stall=%b result=%h early=%0d expected 0 0 %h 0",
                     ready, stall_div, result, early_ready, held);
        end
        @(posedge clk);
        #1;
        run_div(32'd20, 32'd3, 1'b0, "after_annul_20_3", t);
        checks++;
        if (result !== {32'd2, 32'd6}) begin
            errors++;
            $display("[TB] FAIL after_annul literal: got %h expected 0000000200000006", result);
        end
    endtask

    // Synchronous reset in the middle of an operation.
    task automatic test_reset_mid();
        bit saw_ready;
        a          = 32'd999;
        b          = 32'd4;
        signed_div = 1'b0;
        start      = 1'b1;
        saw_ready  = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
        end
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_div !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_during_rst: got %b expected 0", stall_div);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || result !== '0 || stall_div !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got ready=%b stall=%b result=%h expected 0 0 0", ready, stall_div, result);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready === 1'b1) saw_ready = 1;
        end
        checks++;
        if (saw_ready || result !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_quiet: got ready_seen=%0d result=%h expected 0 0", saw_ready, result);
        end
        @(posedge clk);
        #1;
        last_res = '0;
    endtask

    // Two divides with start held straight across the END cycle.
    task automatic test_back_to_back();
        int t1;
        int t2;
        run_div(32'd1000, 32'd7, 1'b0, "b2b_first", t1);
        run_div(32'hFFFFFF9C, 32'd9, 1'b1, "b2b_second", t2);
        checks++;
        if (t2 - t1 != W + 2) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles expected %0d", t2 - t1, W + 2);
        end
    endtask

    task automatic test_random();
        int t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom >> $urandom_range(0, 30));
            rs = 1'($urandom);
            run_div(ra, rb, rs, $sformatf("random_%0d", i), t);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cycle_count = 0;
        last_res    = '0;
        rst         = 1'b1;
        a           = '0;
        b           = '0;
        signed_div  = 1'b0;
        start       = 1'b0;
        annul       = 1'b0;
        test_reset();
        test_basic();
        test_signs();
        test_boundaries();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
